// File: rtl/world_clock_pkg.sv
// Shared definitions for the world clock core: mode encodings, button bit
// positions and the hour arithmetic helpers used by the core.
package world_clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'b00,
    MODE_SET_TIME  = 2'b01,
    MODE_SET_ZONE  = 2'b10,
    MODE_SET_ALARM = 2'b11
  } mode_e;

  localparam int BTN_W      = 8;
  localparam int BTN_ALM_EN = 0;
  localparam int BTN_FMT    = 1;
  localparam int BTN_S_INC  = 2;
  localparam int BTN_S_DEC  = 3;
  localparam int BTN_M_INC  = 4;
  localparam int BTN_M_DEC  = 5;
  localparam int BTN_H_INC  = 6;
  localparam int BTN_H_DEC  = 7;

  typedef struct packed {
    logic [4:0] hour;
    logic       pm;
  } hour12_t;

  // Local hour plus a signed zone offset, folded back into 0..23.
  // The raw sum spans -23..46, so a single +/-24 correction is enough.
  function automatic logic [4:0] zone_wrap(input logic [4:0] hour,
                                           input logic signed [5:0] offset);
    logic signed [6:0] sum;
    sum = $signed({2'b00, hour}) + $signed({offset[5], offset});
    if (sum < 7'sd0) begin
      sum = sum + 7'sd24;
    end else if (sum >= 7'sd24) begin
      sum = sum - 7'sd24;
    end
    return sum[4:0];
  endfunction

  // 24h hour to 12h display hour; pm is valid regardless of format.
  function automatic hour12_t to_12h(input logic [4:0] hour);
    hour12_t r;
    r.pm = (hour >= 5'd12);
    if (hour == 5'd0) begin
      r.hour = 5'd12;
    end else if (hour > 5'd12) begin
      r.hour = hour - 5'd12;
    end else begin
      r.hour = hour;
    end
    return r;
  endfunction

  // Single-field increment/decrement that wraps between 0 and top, no carry.
  function automatic logic [5:0] wrap_step(input logic [5:0] val,
                                           input logic [5:0] top,
                                           input logic       up);
    if (up) begin
      return (val == top) ? 6'd0 : val + 6'd1;
    end
    return (val == 6'd0) ? top : val - 6'd1;
  endfunction

endpackage

// File: rtl/world_clock_core_btn_edge_detect.sv
// Registered rising-edge detector for the debounced panel buttons.
// A held button produces exactly one pulse, one cycle after it is sampled high.
module btn_edge_detect #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] level_q;

  // Remember last level and emit a one-cycle pulse on each 0->1 transition
  always_ff @(posedge clock) begin
    if (!reset) begin
      level_q <= '0;
      rise    <= '0;
    end else begin
      level_q <= level;
      rise    <= level & ~level_q;
    end
  end

endmodule

// File: rtl/world_clock_core.sv
// World clock timekeeping core: local time, selectable zone time, 12/24h
// formatting, a daily alarm and a change strobe for the LCD formatter.
module world_clock_core
  import world_clock_pkg::*;
#(
  parameter int                      TICKS_PER_SEC = 1000,
  parameter int                      NUM_ZONES     = 4,
  parameter logic [6*NUM_ZONES-1:0]  ZONE_OFFSETS  = 24'b000000_111111_110010_000000,
  parameter int                      DEFAULT_ZONE  = 0,
  parameter int                      ALARM_SECS    = 30
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [1:0]                                    mode,
  input  logic [7:0]                                    button,
  output logic [4:0]                                    hour,
  output logic [5:0]                                    minute,
  output logic [5:0]                                    second,
  output logic [$clog2((NUM_ZONES > 1) ? NUM_ZONES : 2)-1:0] zone_sel,
  output logic [4:0]                                    zone_hour,
  output logic [4:0]                                    disp_hour,
  output logic [4:0]                                    zone_disp_hour,
  output logic                                          pm,
  output logic                                          zone_pm,
  output logic                                          fmt_12h,
  output logic [4:0]                                    alarm_hour,
  output logic [5:0]                                    alarm_minute,
  output logic                                          alarm_en,
  output logic                                          alarm_ring,
  output logic                                          sec_pulse,
  output logic                                          changed
);

  localparam int ZW = $clog2((NUM_ZONES > 1) ? NUM_ZONES : 2);
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int AW = $clog2(ALARM_SECS + 1);
  localparam int TW = 18 + ZW;

  mode_e            md;
  logic [BTN_W-1:0] edges;
  logic             any_edge;
  logic             one_edge;
  logic             act;
  logic             alm_toggle;
  logic [PW-1:0]    presc;
  logic             tick;
  logic [4:0]       nxt_hour;
  logic [5:0]       nxt_min;
  logic [5:0]       nxt_sec;
  logic             ring_hit;
  logic [AW-1:0]    ring_cnt;
  logic [TW-1:0]    track_cur;
  logic [TW-1:0]    track_q;
  logic [5:0]       zone_offs [2**ZW];
  hour12_t          loc12;
  hour12_t          zon12;

  assign md = mode_e'(mode);

  btn_edge_detect #(.WIDTH(BTN_W)) u_edges (
    .clock (clock),
    .reset (reset),
    .level (button),
    .rise  (edges)
  );

  // Only a lone edge is acted on; while ringing, edges just silence the alarm
  assign any_edge   = |edges;
  assign one_edge   = $onehot(edges);
  assign act        = one_edge && !alarm_ring;
  assign alm_toggle = one_edge && edges[BTN_ALM_EN];

  assign tick = (md == MODE_RUN) && (presc == PW'(TICKS_PER_SEC - 1));

  // Next time-of-day for a RUN second rollover, carrying through min and hour
  always_comb begin
    nxt_hour = hour;
    nxt_min  = minute;
    nxt_sec  = second + 6'd1;
    if (second == 6'd59) begin
      nxt_sec = 6'd0;
      nxt_min = minute + 6'd1;
      if (minute == 6'd59) begin
        nxt_min  = 6'd0;
        nxt_hour = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
      end
    end
  end

  assign ring_hit = tick && alarm_en && (nxt_hour == alarm_hour) &&
                    (nxt_min == alarm_minute) && (nxt_sec == 6'd0);

  // Prescaler runs only in RUN, so returning to RUN always starts a full second
  always_ff @(posedge clock) begin
    if (!reset) begin
      presc     <= '0;
      sec_pulse <= 1'b0;
    end else begin
      sec_pulse <= tick;
      if (md != MODE_RUN || tick) begin
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Time of day: carry chain in RUN, independent field wrap in SET_TIME
  always_ff @(posedge clock) begin
    if (!reset) begin
      hour   <= 5'd0;
      minute <= 6'd0;
      second <= 6'd0;
    end else if (tick) begin
      hour   <= nxt_hour;
      minute <= nxt_min;
      second <= nxt_sec;
    end else if (md == MODE_SET_TIME && act) begin
      if (edges[BTN_H_INC] || edges[BTN_H_DEC]) begin
        hour <= 5'(wrap_step({1'b0, hour}, 6'd23, edges[BTN_H_INC]));
      end
      if (edges[BTN_M_INC] || edges[BTN_M_DEC]) begin
        minute <= wrap_step(minute, 6'd59, edges[BTN_M_INC]);
      end
      if (edges[BTN_S_INC] || edges[BTN_S_DEC]) begin
        second <= wrap_step(second, 6'd59, edges[BTN_S_INC]);
      end
    end
  end

  // Zone selection steps through 0..NUM_ZONES-1 with wrap
  always_ff @(posedge clock) begin
    if (!reset) begin
      zone_sel <= ZW'(DEFAULT_ZONE);
    end else if (md == MODE_SET_ZONE && act) begin
      if (edges[BTN_H_INC]) begin
        zone_sel <= (zone_sel == ZW'(NUM_ZONES - 1)) ? '0 : zone_sel + 1'b1;
      end else if (edges[BTN_H_DEC]) begin
        zone_sel <= (zone_sel == '0) ? ZW'(NUM_ZONES - 1) : zone_sel - 1'b1;
      end
    end
  end

  // Display format, alarm enable and alarm time settings
  always_ff @(posedge clock) begin
    if (!reset) begin
      fmt_12h      <= 1'b0;
      alarm_en     <= 1'b0;
      alarm_hour   <= 5'd0;
      alarm_minute <= 6'd0;
    end else begin
      if (act && edges[BTN_FMT]) begin
        fmt_12h <= ~fmt_12h;
      end
      if (alm_toggle) begin
        alarm_en <= ~alarm_en;
      end
      if (md == MODE_SET_ALARM && act) begin
        if (edges[BTN_H_INC] || edges[BTN_H_DEC]) begin
          alarm_hour <= 5'(wrap_step({1'b0, alarm_hour}, 6'd23, edges[BTN_H_INC]));
        end
        if (edges[BTN_M_INC] || edges[BTN_M_DEC]) begin
          alarm_minute <= wrap_step(alarm_minute, 6'd59, edges[BTN_M_INC]);
        end
      end
    end
  end

  // Alarm ring: starts on the rollover into HH:MM:00, times out after ALARM_SECS seconds
  always_ff @(posedge clock) begin
    if (!reset) begin
      alarm_ring <= 1'b0;
      ring_cnt   <= '0;
    end else if (any_edge || md != MODE_RUN || !alarm_en) begin
      alarm_ring <= 1'b0;
    end else if (ring_hit) begin
      alarm_ring <= 1'b1;
      ring_cnt   <= '0;
    end else if (alarm_ring && tick) begin
      ring_cnt <= ring_cnt + 1'b1;
      if (ring_cnt == AW'(ALARM_SECS - 1)) begin
        alarm_ring <= 1'b0;
      end
    end
  end

  assign track_cur = {hour, minute, second, zone_sel, fmt_12h};

  // Change strobe: any tracked field differing from last cycle's copy
  always_ff @(posedge clock) begin
    if (!reset) begin
      track_q <= {5'd0, 6'd0, 6'd0, ZW'(DEFAULT_ZONE), 1'b0};
      changed <= 1'b0;
    end else begin
      track_q <= track_cur;
      changed <= (track_cur != track_q);
    end
  end

  for (genvar g = 0; g < 2**ZW; g++) begin : g_offs
    if (g < NUM_ZONES) begin : g_used
      assign zone_offs[g] = ZONE_OFFSETS[6*g +: 6];
    end else begin : g_pad
      assign zone_offs[g] = 6'd0;
    end
  end

  assign zone_hour      = zone_wrap(hour, zone_offs[zone_sel]);
  assign loc12          = to_12h(hour);
  assign zon12          = to_12h(zone_hour);
  assign disp_hour      = fmt_12h ? loc12.hour : hour;
  assign zone_disp_hour = fmt_12h ? zon12.hour : zone_hour;
  assign pm             = loc12.pm;
  assign zone_pm        = zon12.pm;

endmodule

// File: tb/tb_world_clock_core.sv
// Bench for world_clock_core: a seconds-of-day model compared every cycle,
// plus directed scenarios with literal expected values.
module tb_world_clock_core;

  localparam int T  = 4;
  localparam int NZ = 3;
  localparam int AS = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [7:0] button;
  logic [4:0] hour, zone_hour, disp_hour, zone_disp_hour, alarm_hour;
  logic [5:0] minute, second, alarm_minute;
  logic [1:0] zone_sel;
  logic       pm, zone_pm, fmt_12h, alarm_en, alarm_ring, sec_pulse, changed;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  world_clock_core #(
    .TICKS_PER_SEC (T),
    .NUM_ZONES     (NZ),
    .ZONE_OFFSETS  (18'b110010_111111_000000),
    .DEFAULT_ZONE  (0),
    .ALARM_SECS    (AS)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .mode           (mode),
    .button         (button),
    .hour           (hour),
    .minute         (minute),
    .second         (second),
    .zone_sel       (zone_sel),
    .zone_hour      (zone_hour),
    .disp_hour      (disp_hour),
    .zone_disp_hour (zone_disp_hour),
    .pm             (pm),
    .zone_pm        (zone_pm),
    .fmt_12h        (fmt_12h),
    .alarm_hour     (alarm_hour),
    .alarm_minute   (alarm_minute),
    .alarm_en       (alarm_en),
    .alarm_ring     (alarm_ring),
    .sec_pulse      (sec_pulse),
    .changed        (changed)
  );

  always #5 clock = ~clock;

  // Model state: time kept as seconds since midnight
  int         m_tod, m_presc, m_zone, m_ah, m_am, m_rcnt, m_snap;
  logic       m_fmt, m_aen, m_ring, m_pulse, m_changed;
  logic [7:0] m_prevbtn, m_pend;
  int         zone_off [NZ] = '{0, -1, -14};

  function automatic int h12(input int h);
    return (h % 12 == 0) ? 12 : h % 12;
  endfunction

  always @(posedge clock) begin : model
    int h, mi, s, snap, n;
    logic [7:0] act;
    logic tk, hit, aen_old, ring_old;
    if (!reset) begin
      m_tod = 0; m_presc = 0; m_zone = 0; m_ah = 0; m_am = 0; m_rcnt = 0; m_snap = 0;
      m_fmt = 0; m_aen = 0; m_ring = 0; m_pulse = 0; m_changed = 0;
      m_prevbtn = 0; m_pend = 0;
    end else begin
      act       = m_pend;
      m_pend    = button & ~m_prevbtn;
      m_prevbtn = button;
      snap      = m_tod * 8 + m_zone * 2 + int'(m_fmt);
      m_changed = (snap != m_snap);
      m_snap    = snap;
      n         = $countones(act);
      aen_old   = m_aen;
      ring_old  = m_ring;
      tk        = 0;
      if (mode == 2'd0) begin
        if (m_presc == T - 1) begin m_presc = 0; tk = 1; end
        else m_presc = m_presc + 1;
      end else begin
        m_presc = 0;
      end
      m_pulse = tk;
      hit = tk && aen_old && (((m_tod + 1) % 86400) == (m_ah * 60 + m_am) * 60);
      if (act != 0 || mode != 2'd0 || !aen_old) m_ring = 0;
      else if (hit) begin m_ring = 1; m_rcnt = 0; end
      else if (m_ring && tk) begin
        m_rcnt = m_rcnt + 1;
        if (m_rcnt == AS) m_ring = 0;
      end
      if (tk) m_tod = (m_tod + 1) % 86400;
      if (n == 1 && act[0]) m_aen = ~m_aen;
      if (n == 1 && !ring_old) begin
        if (act[1]) m_fmt = ~m_fmt;
        h = m_tod / 3600; mi = (m_tod / 60) % 60; s = m_tod % 60;
        case (mode)
          2'd1: begin
            if (act[7]) h = (h + 23) % 24;
            if (act[6]) h = (h + 1) % 24;
            if (act[5]) mi = (mi + 59) % 60;
            if (act[4]) mi = (mi + 1) % 60;
            if (act[3]) s = (s + 59) % 60;
            if (act[2]) s = (s + 1) % 60;
            m_tod = h * 3600 + mi * 60 + s;
          end
          2'd2: begin
            if (act[6]) m_zone = (m_zone + 1) % NZ;
            if (act[7]) m_zone = (m_zone + NZ - 1) % NZ;
          end
          2'd3: begin
            if (act[7]) m_ah = (m_ah + 23) % 24;
            if (act[6]) m_ah = (m_ah + 1) % 24;
            if (act[5]) m_am = (m_am + 59) % 60;
            if (act[4]) m_am = (m_am + 1) % 60;
          end
          default: ;
        endcase
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clock) begin : compare
    int eh, em, es, ezh, edh, ezdh;
    logic [51:0] exp_v, got_v;
    if (cmp_en) begin
      eh   = m_tod / 3600;
      em   = (m_tod / 60) % 60;
      es   = m_tod % 60;
      ezh  = (eh + zone_off[m_zone] + 24) % 24;
      edh  = m_fmt ? h12(eh) : eh;
      ezdh = m_fmt ? h12(ezh) : ezh;
      exp_v = {5'(eh), 6'(em), 6'(es), 2'(m_zone), 5'(ezh), 5'(edh), 5'(ezdh),
               (eh >= 12), (ezh >= 12), m_fmt, 5'(m_ah), 6'(m_am),
               m_aen, m_ring, m_pulse, m_changed};
      got_v = {hour, minute, second, zone_sel, zone_hour, disp_hour, zone_disp_hour,
               pm, zone_pm, fmt_12h, alarm_hour, alarm_minute,
               alarm_en, alarm_ring, sec_pulse, changed};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL model_compare t=%0t got=%h expected=%h", $time, got_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input int act_v, input int exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input logic [7:0] b);
    button = b;
    step(1);
    button = 8'h00;
    step(2);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hour"}, hour, 0);
    chk({tag, "_minute"}, minute, 0);
    chk({tag, "_second"}, second, 0);
    chk({tag, "_zone_sel"}, zone_sel, 0);
    chk({tag, "_fmt"}, fmt_12h, 0);
    chk({tag, "_disp_hour"}, disp_hour, 0);
    chk({tag, "_alarm_hour"}, alarm_hour, 0);
    chk({tag, "_alarm_minute"}, alarm_minute, 0);
    chk({tag, "_alarm_en"}, alarm_en, 0);
    chk({tag, "_ring"}, alarm_ring, 0);
    chk({tag, "_sec_pulse"}, sec_pulse, 0);
    chk({tag, "_changed"}, changed, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    int pulses, chg;
    reset = 1'b0; mode = 2'd0; button = 8'h00;
    step(2);
    cmp_en = 1'b1;
    chk_reset_vals("por");

    // Free run from reset: 80 cycles = 20 seconds
    reset = 1'b1;
    pulses = 0; chg = 0;
    repeat (80) begin step(1); pulses += int'(sec_pulse); chg += int'(changed); end
    chk("run20_hour", hour, 0);
    chk("run20_minute", minute, 0);
    chk("run20_second", second, 20);
    chk("run20_model_tod", m_tod, 20);
    step(1); pulses += int'(sec_pulse); chg += int'(changed);
    chk("run20_pulses", pulses, 20);
    chk("run20_changed", chg, 20);

    // Set 23:59:59 by wrapping each field downward, then roll over in RUN
    reset = 1'b0; step(1); reset = 1'b1;
    mode = 2'd1;
    press(8'h80); press(8'h20); press(8'h08);
    chk("set_hour", hour, 23);
    chk("set_minute", minute, 59);
    chk("set_second", second, 59);
    mode = 2'd0; chg = 0;
    repeat (4) begin step(1); chg += int'(changed); end
    chk("roll_hour", hour, 0);
    chk("roll_minute", minute, 0);
    chk("roll_second", second, 0);
    chk("roll_pulse", sec_pulse, 1);
    step(1); chg += int'(changed);
    chk("roll_changed", chg, 1);

    // Zone stepping and formatting at hour 05
    mode = 2'd1;
    repeat (5) press(8'h40);
    chk("h5_hour", hour, 5);
    mode = 2'd2;
    press(8'h40); chk("zone_1", zone_sel, 1); chk("zone1_hour", zone_hour, 4);
    press(8'h40); chk("zone_2", zone_sel, 2); chk("zone2_hour", zone_hour, 15);
    chk("zone2_pm", zone_pm, 1);
    press(8'h40); chk("zone_wrap0", zone_sel, 0);
    press(8'h80); chk("zone_dec_wrap", zone_sel, 2);
    press(8'h02);
    chk("fmt_on", fmt_12h, 1);
    chk("fmt_zone_disp", zone_disp_hour, 3);
    chk("fmt_disp", disp_hour, 5);
    chk("fmt_pm", pm, 0);

    // Simultaneous edges ignored; held button acts once
    mode = 2'd1;
    press(8'h50);
    chk("dual_hour", hour, 5);
    chk("dual_minute", minute, 0);
    button = 8'h40; step(10); button = 8'h00; step(2);
    chk("held_hour", hour, 6);

    // Alarm 00:01 enabled; s_inc ignored in SET_ALARM
    mode = 2'd3;
    press(8'h10); press(8'h04); press(8'h01);
    chk("alarm_min", alarm_minute, 1);
    chk("alarm_hr", alarm_hour, 0);
    chk("alarm_en", alarm_en, 1);
    mode = 2'd1;
    repeat (6) press(8'h80);
    press(8'h08); press(8'h08);
    chk("pre_alarm_sec", second, 58);
    chk("pre_alarm_ring", alarm_ring, 0);
    mode = 2'd0;
    step(7); chk("ring_early", alarm_ring, 0);
    step(1);
    chk("ring_on", alarm_ring, 1);
    chk("ring_minute", minute, 1);
    chk("ring_second", second, 0);
    chk("ring_disp12", disp_hour, 12);
    press(8'h04);
    chk("ack_ring", alarm_ring, 0);
    chk("ack_minute", minute, 1);
    chk("ack_second", second, 0);
    chk("ack_alarm_en", alarm_en, 1);

    // Ring times out after AS seconds without acknowledgement
    mode = 2'd1;
    press(8'h20); press(8'h08); press(8'h08);
    mode = 2'd0;
    step(8); chk("to_ring_on", alarm_ring, 1);
    step(11); chk("to_ring_hold", alarm_ring, 1);
    step(1); chk("to_ring_off", alarm_ring, 0);

    // Reset while ringing
    mode = 2'd1;
    press(8'h20);
    repeat (5) press(8'h08);
    chk("rst_pre_sec", second, 58);
    mode = 2'd0;
    step(8); chk("rst_ring_on", alarm_ring, 1);
    reset = 1'b0; step(1); reset = 1'b1;
    chk_reset_vals("midrst");
    step(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
